// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between fetch, mem stage, memory port and the arbiter.
// The arbiter binds to slave; the requester/memory side binds to master.
interface mem_port_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int RES_W = 16
);
    logic             if_r_v;
    logic [XLEN-1:0]  if_adr;
    logic             if_ready;
    logic             if_hit;
    logic [RES_W-1:0] if_res;
    logic             if_error;
    logic             flush;
    logic             d_r_v;
    logic             d_w_v;
    logic [XLEN-1:0]  d_adr;
    logic [XLEN-1:0]  d_data;
    logic [3:0]       d_strobe;
    logic             d_ready;
    logic             d_hit;
    logic [RES_W-1:0] d_res;
    logic             d_error;
    logic             m_r_v;
    logic             m_w_v;
    logic [XLEN-1:0]  m_adr;
    logic [XLEN-1:0]  m_data;
    logic [3:0]       m_strobe;
    logic             m_ready;
    logic             m_hit;
    logic [RES_W-1:0] m_res;
    logic             m_error;

    modport slave (
        input  if_r_v, if_adr, flush,
        input  d_r_v, d_w_v, d_adr, d_data, d_strobe,
        input  m_ready, m_hit, m_res, m_error,
        output if_ready, if_hit, if_res, if_error,
        output d_ready, d_hit, d_res, d_error,
        output m_r_v, m_w_v, m_adr, m_data, m_strobe
    );

    modport master (
        output if_r_v, if_adr, flush,
        output d_r_v, d_w_v, d_adr, d_data, d_strobe,
        output m_ready, m_hit, m_res, m_error,
        input  if_ready, if_hit, if_res, if_error,
        input  d_ready, d_hit, d_res, d_error,
        input  m_r_v, m_w_v, m_adr, m_data, m_strobe
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the core memory port between fetch and the mem stage, one
// transaction outstanding, data priority with a fetch starvation bound.
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int RES_W      = 16,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

    state_t        state, state_nx;
    owner_t        owner, owner_nx;
    logic          drop, drop_nx;
    logic [CW-1:0] starve_cnt, starve_nx;
    logic          d_win, f_win, if_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            drop       <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            drop       <= drop_nx;
            starve_cnt <= starve_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        owner_nx     = owner;
        drop_nx      = drop;
        starve_nx    = starve_cnt;
        d_win        = 1'b0;
        f_win        = 1'b0;
        if_wait      = bus.if_r_v & ~bus.flush;
        bus.if_ready = 1'b0;
        bus.if_hit   = 1'b0;
        bus.if_res   = '0;
        bus.if_error = 1'b0;
        bus.d_ready  = 1'b0;
        bus.d_hit    = 1'b0;
        bus.d_res    = '0;
        bus.d_error  = 1'b0;
        bus.m_r_v    = 1'b0;
        bus.m_w_v    = 1'b0;
        bus.m_adr    = '0;
        bus.m_data   = '0;
        bus.m_strobe = 4'b0000;

        // Outputs stay quiet while reset is held, whatever the inputs do.
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    d_win = (bus.d_r_v | bus.d_w_v) && (starve_cnt < SMAX);
                    f_win = ~d_win & if_wait;
                    unique case (1'b1)
                        d_win: begin
                            bus.m_w_v    = bus.d_w_v;
                            bus.m_r_v    = bus.d_r_v & ~bus.d_w_v;
                            bus.m_adr    = bus.d_adr;
                            bus.m_data   = bus.d_data;
                            bus.m_strobe = bus.d_strobe;
                            if (bus.m_ready) begin
                                bus.d_ready = 1'b1;
                                state_nx    = BUSY;
                                owner_nx    = OWN_D;
                                drop_nx     = 1'b0;
                                if (!if_wait)
                                    starve_nx = '0;
                                else if (starve_cnt != SMAX)
                                    starve_nx = starve_cnt + CW'(1);
                            end
                        end
                        f_win: begin
                            bus.m_r_v    = 1'b1;
                            bus.m_adr    = bus.if_adr;
                            bus.m_strobe = 4'b1111;
                            if (bus.m_ready) begin
                                bus.if_ready = 1'b1;
                                state_nx     = BUSY;
                                owner_nx     = OWN_IF;
                                drop_nx      = 1'b0;
                                starve_nx    = '0;
                            end
                        end
                        default: ;
                    endcase
                end
                BUSY: begin
                    if (owner == OWN_IF && bus.flush)
                        drop_nx = 1'b1;
                    if (bus.m_hit) begin
                        if (owner == OWN_D) begin
                            bus.d_hit   = 1'b1;
                            bus.d_res   = bus.m_res;
                            bus.d_error = bus.m_error;
                        end else if (owner == OWN_IF && !drop_nx) begin
                            bus.if_hit   = 1'b1;
                            bus.if_res   = bus.m_res;
                            bus.if_error = bus.m_error;
                        end
                        state_nx = IDLE;
                        owner_nx = OWN_NONE;
                        drop_nx  = 1'b0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a
// transaction-level model of the shared port.
module tb_mem_port_arbiter;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(32), .RES_W(16)) bus ();

    mem_port_arbiter #(.XLEN(32), .RES_W(16), .STARVE_MAX(SM)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    // model: is a transaction outstanding, who owns it, fetch discarded,
    // how many data grants fetch has sat through
    bit mb = 0;
    bit mown_d = 0;
    bit mdrop = 0;
    int mc = 0;

    bit got_if_ready, got_d_ready;
    bit log_en = 0;
    string glog = "";

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit dw, fw;
        logic e_ir, e_ih, e_ie, e_dr, e_dh, e_de, e_mr, e_mw;
        logic [15:0] e_ires, e_dres;
        logic [31:0] e_adr, e_dat;
        logic [3:0] e_stb;
        dw = 0; fw = 0;
        e_ir = 0; e_ih = 0; e_ie = 0; e_dr = 0; e_dh = 0; e_de = 0;
        e_mr = 0; e_mw = 0; e_ires = 0; e_dres = 0;
        e_adr = 0; e_dat = 0; e_stb = 0;
        if (rst_n) begin
            if (!mb) begin
                dw = (bus.d_r_v || bus.d_w_v) && (mc < SM);
                fw = !dw && bus.if_r_v && !bus.flush;
                if (dw) begin
                    e_mw = bus.d_w_v;
                    e_mr = bus.d_r_v && !bus.d_w_v;
                    e_adr = bus.d_adr;
                    e_dat = bus.d_data;
                    e_stb = bus.d_strobe;
                    e_dr = bus.m_ready;
                end else if (fw) begin
                    e_mr = 1;
                    e_adr = bus.if_adr;
                    e_stb = 4'hf;
                    e_ir = bus.m_ready;
                end
            end else if (bus.m_hit) begin
                if (mown_d) begin
                    e_dh = 1; e_dres = bus.m_res; e_de = bus.m_error;
                end else if (!mdrop && !bus.flush) begin
                    e_ih = 1; e_ires = bus.m_res; e_ie = bus.m_error;
                end
            end
        end
        chk("if_ready", bus.if_ready, e_ir);
        chk("if_hit", bus.if_hit, e_ih);
        chk("if_res", bus.if_res, e_ires);
        chk("if_error", bus.if_error, e_ie);
        chk("d_ready", bus.d_ready, e_dr);
        chk("d_hit", bus.d_hit, e_dh);
        chk("d_res", bus.d_res, e_dres);
        chk("d_error", bus.d_error, e_de);
        chk("m_r_v", bus.m_r_v, e_mr);
        chk("m_w_v", bus.m_w_v, e_mw);
        chk("m_adr", bus.m_adr, e_adr);
        chk("m_data", bus.m_data, e_dat);
        chk("m_strobe", bus.m_strobe, e_stb);

        if (!rst_n) begin
            mb = 0; mdrop = 0; mc = 0;
        end else if (!mb) begin
            if ((dw || fw) && bus.m_ready) begin
                mb = 1; mown_d = dw; mdrop = 0;
                if (fw || !(bus.if_r_v && !bus.flush)) mc = 0;
                else if (mc < SM) mc++;
            end
        end else begin
            if (!mown_d && bus.flush) mdrop = 1;
            if (bus.m_hit) begin mb = 0; mdrop = 0; end
        end

        got_if_ready = bus.if_ready;
        got_d_ready = bus.d_ready;
        if (log_en && bus.d_ready) glog = {glog, "D"};
        if (log_en && bus.if_ready) glog = {glog, "F"};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        bus.if_r_v = 0; bus.if_adr = 0; bus.flush = 0;
        bus.d_r_v = 0; bus.d_w_v = 0; bus.d_adr = 0;
        bus.d_data = 0; bus.d_strobe = 0;
        bus.m_ready = 0; bus.m_hit = 0; bus.m_res = 0; bus.m_error = 0;
    endtask

    function automatic logic [31:0] all_outs();
        return {bus.if_ready, bus.if_hit, bus.if_error, bus.d_ready,
                bus.d_hit, bus.d_error, bus.m_r_v, bus.m_w_v,
                bus.m_strobe, bus.if_res ^ bus.d_res,
                bus.m_adr[7:0] | bus.m_data[7:0]};
    endfunction

    initial begin
        bit mem_out;
        int mem_wait;
        int kind;
        clr();
        bus.d_r_v = 1; bus.m_ready = 1; bus.d_adr = 32'h40;
        mid();
        chk("rst_quiet", all_outs(), 0);
        clr();
        step(); step();
        rst_n = 1;
        mid();
        chk("post_rst", all_outs(), 0);
        step();

        // 1: plain data read
        bus.d_r_v = 1; bus.d_adr = 32'h100; bus.m_ready = 1;
        mid();
        chk("t1_ready", bus.d_ready, 1);
        chk("t1_adr", bus.m_adr, 32'h100);
        step();
        bus.d_r_v = 0; bus.m_ready = 0; bus.m_hit = 1; bus.m_res = 16'hBEEF;
        mid();
        chk("t1_hit", bus.d_hit, 1);
        chk("t1_res", bus.d_res, 32'hBEEF);
        chk("t1_ifhit", bus.if_hit, 0);
        step();
        clr();
        step();

        // 2: starvation bound
        bus.if_r_v = 1; bus.if_adr = 32'h1000;
        bus.d_r_v = 1; bus.d_adr = 32'h2000;
        bus.m_ready = 1; bus.m_hit = 1; bus.m_res = 16'h0001;
        glog = ""; log_en = 1;
        repeat (20) step();
        log_en = 0;
        checks++;
        if (glog != "DDDDFDDDDF") begin
            failures++;
            $display("FAIL t2_order actual=%s required=DDDDFDDDDF", glog);
        end
        clr();
        step();

        // 3: flushed fetch response is swallowed
        bus.if_r_v = 1; bus.if_adr = 32'h44; bus.m_ready = 1;
        mid();
        chk("t3_ifready", bus.if_ready, 1);
        step();
        clr(); bus.flush = 1;
        mid();
        chk("t3_noearly", bus.if_hit, 0);
        step();
        clr(); bus.m_hit = 1; bus.m_res = 16'h1234;
        mid();
        chk("t3_dropped", bus.if_hit, 0);
        chk("t3_nodhit", bus.d_hit, 0);
        step();
        clr(); bus.d_r_v = 1; bus.d_adr = 32'h300; bus.m_ready = 1;
        mid();
        chk("t3_dready", bus.d_ready, 1);
        chk("t3_dadr", bus.m_adr, 32'h300);
        step();
        clr(); bus.m_hit = 1; bus.m_res = 16'h5555;
        mid();
        chk("t3_dhit", bus.d_hit, 1);
        chk("t3_dres", bus.d_res, 32'h5555);
        step();
        clr();

        // 4: write stalled by memory
        bus.d_w_v = 1; bus.d_adr = 32'h200;
        bus.d_data = 32'hCAFEF00D; bus.d_strobe = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t4_wv", bus.m_w_v, 1);
            chk("t4_rv", bus.m_r_v, 0);
            chk("t4_adr", bus.m_adr, 32'h200);
            chk("t4_data", bus.m_data, 32'hCAFEF00D);
            chk("t4_stb", bus.m_strobe, 4'b0011);
            chk("t4_noready", bus.d_ready, 0);
            step();
        end
        bus.m_ready = 1;
        mid();
        chk("t4_ready", bus.d_ready, 1);
        step();
        clr(); bus.m_hit = 1;
        mid();
        chk("t4_ack", bus.d_hit, 1);
        step();
        clr();

        // 5: reset while busy
        bus.if_r_v = 1; bus.d_r_v = 1; bus.d_adr = 32'h500; bus.m_ready = 1;
        mid();
        chk("t5_dgrant", bus.d_ready, 1);
        step();
        clr(); rst_n = 0;
        mid();
        chk("t5_quiet", all_outs(), 0);
        chk("t5_cnt", 32'(dut.starve_cnt), 0);
        step();
        rst_n = 1; bus.m_hit = 1; bus.m_res = 16'h7777;
        mid();
        chk("t5_nodhit", bus.d_hit, 0);
        chk("t5_noifhit", bus.if_hit, 0);
        step();
        clr();

        // 6: fetch error
        bus.if_r_v = 1; bus.if_adr = 32'h600; bus.m_ready = 1;
        mid();
        chk("t6_ready", bus.if_ready, 1);
        step();
        clr(); bus.m_hit = 1; bus.m_error = 1; bus.m_res = 16'h0F0F;
        mid();
        chk("t6_hit", bus.if_hit, 1);
        chk("t6_err", bus.if_error, 1);
        chk("t6_derr", bus.d_error, 0);
        chk("t6_res", bus.if_res, 32'h0F0F);
        step();
        clr();
        step();

        // random traffic, checked every cycle by the model
        mem_out = 0;
        mem_wait = 0;
        got_if_ready = 0;
        got_d_ready = 0;
        for (int c = 0; c < 4000; c++) begin
            if (got_if_ready) bus.if_r_v = 0;
            if (got_d_ready) begin bus.d_r_v = 0; bus.d_w_v = 0; end
            bus.m_hit = 0;
            if (got_if_ready || got_d_ready) begin
                mem_out = 1;
                mem_wait = $urandom_range(0, 2);
            end
            if (mem_out) begin
                if (mem_wait == 0) begin
                    bus.m_hit = 1;
                    mem_out = 0;
                end else mem_wait--;
            end else if ($urandom_range(0, 7) == 0) bus.m_hit = 1;
            bus.m_res = 16'($urandom);
            bus.m_error = ($urandom_range(0, 5) == 0);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            if (!bus.if_r_v && $urandom_range(0, 2) == 0) begin
                bus.if_r_v = 1;
                bus.if_adr = $urandom;
            end
            if (!bus.d_r_v && !bus.d_w_v && $urandom_range(0, 2) == 0) begin
                kind = $urandom_range(0, 15);
                bus.d_r_v = (kind < 8) || (kind == 15);
                bus.d_w_v = (kind >= 8);
                bus.d_adr = $urandom;
                bus.d_data = $urandom;
                bus.d_strobe = 4'($urandom);
            end
            step();
        end
        clr();
        repeat (4) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
